// File: rtl/binary_to_bcd_seq_pkg.sv
// binary_to_bcd_seq_pkg: shared definitions for the sequential binary-to-BCD converter.
//   state_e          FSM state encoding (IDLE=0, CALC=1, DONE=2)
//   BcdThresh        digits at or above this value are corrected before a shift
//   BcdCorr          correction added to such a digit
//   BcdMax           largest legal BCD digit, used when saturating on overflow
package binary_to_bcd_seq_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic [3:0] BcdThresh = 4'd5;
  localparam logic [3:0] BcdCorr   = 4'd3;
  localparam logic [3:0] BcdMax    = 4'd9;

endpackage

// File: rtl/binary_to_bcd_seq_digit_adj.sv
// bcd_digit_adj: combinational shift-and-add-3 correction for one BCD digit.
//   digit_i  [3:0]  current digit (0..9)
//   digit_o  [3:0]  digit_i + 3 when digit_i >= 5, else digit_i
// A corrected digit of 5..9 becomes 8..12, so its MSB carries into the next
// digit on the following left shift.
module bcd_digit_adj
  import binary_to_bcd_seq_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= BcdThresh) ? (digit_i + BcdCorr) : digit_i;

endmodule

// File: rtl/binary_to_bcd_seq.sv
// binary_to_bcd_seq: sequential double-dabble binary-to-BCD converter, one shift per cycle.
//   clk      clock, rising edge
//   rst      asynchronous active-high reset
//   in_val   input word valid
//   in_rdy   converter idle, accepting (Moore, registered)
//   in_bin   [p_nbits-1:0] unsigned value, sampled only at the input handshake
//   out_val  result valid (Moore, registered)
//   out_rdy  consumer accepts result
//   out_bcd  [4*p_ndigits-1:0] packed BCD, digit k in bits [4k+3:4k]
//   ovf      only with BINARY_TO_BCD_SEQ_OVERFLOW_EN: result did not fit p_ndigits
// Optional feature macro: BINARY_TO_BCD_SEQ_OVERFLOW_EN. When defined, a value that
// does not fit is reported on ovf and out_bcd saturates to all nines; otherwise the
// carry out of the top digit is dropped and out_bcd = in_bin mod 10^p_ndigits.
module binary_to_bcd_seq
  import binary_to_bcd_seq_pkg::*;
#(
  parameter int unsigned p_nbits   = 8,
  parameter int unsigned p_ndigits = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_val,
  output logic                     in_rdy,
  input  logic [p_nbits-1:0]       in_bin,
  output logic                     out_val,
  input  logic                     out_rdy,
  output logic [4*p_ndigits-1:0]   out_bcd
`ifdef BINARY_TO_BCD_SEQ_OVERFLOW_EN
  ,
  output logic                     ovf
`endif
);

  localparam int unsigned BcdW = 4 * p_ndigits;
  localparam int unsigned CntW = $clog2(p_nbits + 1);

  state_e              state_q;
  logic [p_nbits-1:0]  sh_q;
  logic [BcdW-1:0]     bcd_q;
  logic [CntW-1:0]     cnt_q;
  logic                in_rdy_q;
  logic                out_val_q;

  logic [BcdW-1:0]     bcd_adj;
  logic [BcdW-1:0]     bcd_step;
  logic [p_nbits-1:0]  sh_step;

  for (genvar g = 0; g < p_ndigits; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (bcd_q[4*g +: 4]),
      .digit_o (bcd_adj[4*g +: 4])
    );
  end

  // One double-dabble step: corrected digits and shift register move left as one
  // vector; the top bit of bcd_adj falls off (it is the carry out of the top digit).
  assign bcd_step = {bcd_adj[BcdW-2:0], sh_q[p_nbits-1]};
  assign sh_step  = sh_q << 1;

`ifdef BINARY_TO_BCD_SEQ_OVERFLOW_EN
  logic ovf_q;
  logic carry_out;

  assign carry_out = bcd_adj[BcdW-1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      sh_q      <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      in_rdy_q  <= 1'b1;
      out_val_q <= 1'b0;
`ifdef BINARY_TO_BCD_SEQ_OVERFLOW_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_val) begin
            sh_q     <= in_bin;
            bcd_q    <= '0;
            cnt_q    <= CntW'(p_nbits);
            in_rdy_q <= 1'b0;
            state_q  <= StCalc;
`ifdef BINARY_TO_BCD_SEQ_OVERFLOW_EN
            ovf_q    <= 1'b0;
`endif
          end
        end
        StCalc: begin
          bcd_q <= bcd_step;
          sh_q  <= sh_step;
          cnt_q <= cnt_q - 1'b1;
`ifdef BINARY_TO_BCD_SEQ_OVERFLOW_EN
          if (carry_out) ovf_q <= 1'b1;
`endif
          // cnt_q == 1 means this edge performs the final shift.
          if (cnt_q == CntW'(1)) begin
            out_val_q <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          if (out_rdy) begin
            out_val_q <= 1'b0;
            in_rdy_q  <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: begin
          out_val_q <= 1'b0;
          in_rdy_q  <= 1'b1;
          state_q   <= StIdle;
        end
      endcase
    end
  end

  assign in_rdy  = in_rdy_q;
  assign out_val = out_val_q;

`ifdef BINARY_TO_BCD_SEQ_OVERFLOW_EN
  assign ovf     = out_val_q & ovf_q;
  assign out_bcd = (out_val_q && ovf_q) ? {p_ndigits{BcdMax}} : bcd_q;
`else
  assign out_bcd = bcd_q;
`endif

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// tb_binary_to_bcd_seq: randomized self-checking bench for binary_to_bcd_seq.
// Three instances share clk/rst: 0 = defaults (8 bits, 3 digits), 1 = 8 bits/2 digits,
// 2 = 1 bit/3 digits. Expected results come from decimal arithmetic on the input value.
// Honours BINARY_TO_BCD_SEQ_OVERFLOW_EN for the ovf port and saturation.
module tb_binary_to_bcd_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic       in_val  [3];
  logic [7:0] in_bin  [3];
  logic       out_rdy [3];

  logic        rdy0, rdy1, rdy2;
  logic        val0, val1, val2;
  logic [11:0] bcd0, bcd2;
  logic [7:0]  bcd1;
`ifdef BINARY_TO_BCD_SEQ_OVERFLOW_EN
  logic        ovf0, ovf1, ovf2;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  binary_to_bcd_seq #(.p_nbits(8), .p_ndigits(3)) u_dut0 (
    .clk(clk), .rst(rst), .in_val(in_val[0]), .in_rdy(rdy0), .in_bin(in_bin[0]),
    .out_val(val0), .out_rdy(out_rdy[0]), .out_bcd(bcd0)
`ifdef BINARY_TO_BCD_SEQ_OVERFLOW_EN
    , .ovf(ovf0)
`endif
  );

  binary_to_bcd_seq #(.p_nbits(8), .p_ndigits(2)) u_dut1 (
    .clk(clk), .rst(rst), .in_val(in_val[1]), .in_rdy(rdy1), .in_bin(in_bin[1]),
    .out_val(val1), .out_rdy(out_rdy[1]), .out_bcd(bcd1)
`ifdef BINARY_TO_BCD_SEQ_OVERFLOW_EN
    , .ovf(ovf1)
`endif
  );

  binary_to_bcd_seq #(.p_nbits(1), .p_ndigits(3)) u_dut2 (
    .clk(clk), .rst(rst), .in_val(in_val[2]), .in_rdy(rdy2), .in_bin(in_bin[2][0:0]),
    .out_val(val2), .out_rdy(out_rdy[2]), .out_bcd(bcd2)
`ifdef BINARY_TO_BCD_SEQ_OVERFLOW_EN
    , .ovf(ovf2)
`endif
  );

  function automatic logic rdy_of(input int d);
    return (d == 0) ? rdy0 : (d == 1) ? rdy1 : rdy2;
  endfunction

  function automatic logic val_of(input int d);
    return (d == 0) ? val0 : (d == 1) ? val1 : val2;
  endfunction

  function automatic logic [11:0] bcd_of(input int d);
    return (d == 0) ? bcd0 : (d == 1) ? {4'h0, bcd1} : bcd2;
  endfunction

`ifdef BINARY_TO_BCD_SEQ_OVERFLOW_EN
  function automatic logic ovf_of(input int d);
    return (d == 0) ? ovf0 : (d == 1) ? ovf1 : ovf2;
  endfunction
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference: decimal digits of v, truncated to nd digits or saturated when enabled.
  function automatic void ref_model(input int unsigned v, input int nd,
                                    output logic [11:0] bcd, output logic ov);
    int unsigned lim = 1;
    int unsigned x;
    for (int k = 0; k < nd; k++) lim = lim * 10;
    ov = (v >= lim);
`ifdef BINARY_TO_BCD_SEQ_OVERFLOW_EN
    x = ov ? lim - 1 : v;
`else
    x  = v % lim;
    ov = 1'b0;
`endif
    bcd = '0;
    for (int k = 0; k < nd; k++) begin
      bcd[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
  endfunction

  // One full transaction on instance d, holding out_rdy low for `hold` cycles.
  task automatic convert(input int d, input int unsigned v_in, input int hold);
    int nb;
    int nd;
    int n;
    int unsigned v;
    logic [11:0] eb;
    logic eo;
    nb = (d == 2) ? 1 : 8;
    nd = (d == 1) ? 2 : 3;
    v  = v_in & ((32'd1 << nb) - 1);
    ref_model(v, nd, eb, eo);
    n = 0;
    while (!rdy_of(d) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("idle_in_rdy", 32'(rdy_of(d)), 32'd1);
    in_val[d] = 1'b1;
    in_bin[d] = 8'(v);
    @(posedge clk); #1;
    // Busy phase: junk on in_val/in_bin must be ignored.
    n = 0;
    while (!val_of(d) && n < 40) begin
      check("busy_in_rdy", 32'(rdy_of(d)), 32'd0);
      in_val[d] = 1'($urandom_range(0, 1));
      in_bin[d] = 8'($urandom);
      @(posedge clk); #1; n++;
    end
    // out_val first seen after the p_nbits-th edge following acceptance.
    check("latency", 32'(n), 32'(nb));
    check("out_bcd", 32'(bcd_of(d)), 32'(eb));
`ifdef BINARY_TO_BCD_SEQ_OVERFLOW_EN
    check("ovf", 32'(ovf_of(d)), 32'(eo));
`endif
    repeat (hold) begin
      in_val[d] = 1'($urandom_range(0, 1));
      in_bin[d] = 8'($urandom);
      @(posedge clk); #1;
      check("hold_out_val", 32'(val_of(d)), 32'd1);
      check("hold_out_bcd", 32'(bcd_of(d)), 32'(eb));
    end
    in_val[d]  = 1'b0;
    out_rdy[d] = 1'b1;
    @(posedge clk); #1;
    out_rdy[d] = 1'b0;
    check("post_out_val", 32'(val_of(d)), 32'd0);
    check("post_in_rdy", 32'(rdy_of(d)), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int last;
    int nres;
    for (int d = 0; d < 3; d++) begin
      in_val[d]  = 1'b0;
      in_bin[d]  = '0;
      out_rdy[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check("rst_in_rdy", 32'(rdy_of(d)), 32'd1);
      check("rst_out_val", 32'(val_of(d)), 32'd0);
      check("rst_out_bcd", 32'(bcd_of(d)), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    convert(0, 0, 0);
    convert(0, 255, 0);
    convert(0, 31, 0);
    convert(0, 137, 5);
    for (int v = 0; v < 256; v++) convert(0, v, 0);

    // Abort in the 4th CALC cycle of 200.
    in_val[0] = 1'b1;
    in_bin[0] = 8'd200;
    @(posedge clk); #1;
    in_val[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_in_rdy", 32'(rdy0), 32'd1);
    check("abort_out_val", 32'(val0), 32'd0);
    check("abort_out_bcd", 32'(bcd0), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    convert(0, 42, 0);

    convert(1, 200, 2);
    convert(1, 99, 0);
    convert(1, 100, 0);
    for (int i = 0; i < 30; i++) convert(1, $urandom, $urandom_range(0, 3));

    convert(2, 1, 0);
    convert(2, 0, 0);
    for (int i = 0; i < 8; i++) convert(2, $urandom, $urandom_range(0, 2));

    // Back-to-back with out_rdy tied high on the 1-bit instance.
    out_rdy[2] = 1'b1;
    in_val[2]  = 1'b1;
    in_bin[2]  = 8'd1;
    last = -1;
    nres = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (val2) begin
        check("tput_bcd", 32'(bcd2), 32'h001);
        if (last >= 0) check("tput_gap", 32'(i - last), 32'd3);
        last = i;
        nres++;
      end
    end
    check("tput_count", 32'(nres), 32'd4);
    in_val[2] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    out_rdy[2] = 1'b0;

    for (int i = 0; i < 20; i++) convert(0, $urandom, $urandom_range(0, 4));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
